cond_logic: RTL and testbench
=============================

# cond_logic

Conditional-execution stage directly downstream of the instruction decoder. It holds the architectural NZCV flags and evaluates each instruction's 4-bit condition field against them. It gates the decoder's PCS/RegW/MemW strobes into the final PCSrc/RegWrite/MemWrite, and updates the flags from the ALU when the decoder requests it.

## Interface
Parameters:
- CNT_W, default 32: width of the optional execution/squash counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  instruction-valid / not-stalled; when low, no state changes.
- Cond  in  4  instruction condition field, Instr[31:28].
- ALUFlags  in  4  ALU result flags {N,Z,C,V} for the current instruction.
- FlagW  in  2  from decoder: bit1 = write C,V; bit0 = write N,Z.
- PCS  in  1  from decoder: instruction writes the PC.
- RegW  in  1  from decoder: instruction writes the register file.
- MemW  in  1  from decoder: instruction writes memory.
- PCSrc  out  1  PCS gated by CondEx.
- RegWrite  out  1  RegW gated by CondEx.
- MemWrite  out  1  MemW gated by CondEx.
- CondEx  out  1  condition passed for the current instruction.
- Flags  out  4  registered {N,Z,C,V}, for ADC/SBC carry-in.
- ExecCount  out  CNT_W  executed-instruction count (COND_PERF_CNT_EN only).
- SquashCount  out  CNT_W  squashed-instruction count (COND_PERF_CNT_EN only).

## Operation
- CondEx is a combinational function of Cond and the registered Flags, not ALUFlags.
- EQ 0000: Z. NE 0001: !Z. CS 0010: C. CC 0011: !C. MI 0100: N. PL 0101: !N. VS 0110: V. VC 0111: !V.
- HI 1000: C&!Z. LS 1001: !C|Z. GE 1010: N==V. LT 1011: N!=V. GT 1100: !Z&(N==V). LE 1101: Z|(N!=V). AL 1110: 1. NV 1111: 0 (always squashed).
- Write gating: PCSrc = PCS&CondEx, RegWrite = RegW&CondEx, MemWrite = MemW&CondEx. The outputs follow the inputs regardless of en; the datapath owns gating by en.
- Flag update: at the edge with en&CondEx&FlagW[0], N,Z <= ALUFlags[3:2]. With en&CondEx&FlagW[1], C,V <= ALUFlags[1:0]. The two halves are independent.
- A squashed instruction (CondEx=0) never updates flags, even when FlagW≠0.

## Timing
- Gating and CondEx have zero latency (combinational in-cycle).
- Flags update one cycle after the setting instruction. The next instruction's condition sees the new flags; the same instruction's condition sees the old flags.
- Reset: Flags=4'b0000, ExecCount=0, SquashCount=0. Reset wins over en and any flag write in the same cycle.
- With Flags=0000 after reset: EQ fails, NE passes, AL passes, NV fails.
- en=0: Flags and counters hold. Combinational outputs remain valid.

## Configuration
- COND_PERF_CNT_EN defined: ExecCount and SquashCount ports and registers exist.
  - Each cycle with en=1, ExecCount increments if CondEx, else SquashCount increments.
  - Both counters saturate at 2^CNT_W−1 (no wrap).
- Undefined: the counter ports are absent and no counter logic is built. Behaviour is otherwise identical.

## Structure
- Shared package cond_pkg:
  - enum cond_e (EQ..NV, 4-bit).
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - FlagW bit constants FLAGW_CV=1, FLAGW_NZ=0.
- One sub-module, cond_check: pure combinational (Cond, Flags) -> CondEx. It is reused by any later pipelined variant.
- cond_logic holds the flag register, the gating logic and the optional counters.

## Test plan
- Reset, then Cond=0000 (EQ) with PCS=RegW=MemW=1 -> CondEx=0 and all gated outputs 0. Flags=0000.
- ALUFlags=0100, FlagW=01, Cond=1110 -> next cycle Flags=0100. Then Cond=0000 gives CondEx=1 and RegWrite=RegW.
- Flags=0100, ALUFlags=1011, FlagW=10, Cond=1110 -> Flags=0111 (N,Z held; C,V written).
- Flags=1000, FlagW=11, Cond=0000 (fails), ALUFlags=0110 -> Flags stay 1000, MemWrite=0.
- Sweep all 16 Cond × 16 Flags -> CondEx matches the condition list. NV is always 0 and AL always 1.
- With COND_PERF_CNT_EN: 5 passing and 3 failing cycles, one en=0 cycle in between -> ExecCount=5, SquashCount=3. With CNT_W=4 and 20 passing cycles -> ExecCount saturates at 15.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution stage: condition codes,
// flag bit positions and FlagW strobe bit positions.
package cond_pkg;

  // 4-bit instruction condition field encodings
  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Bit positions inside the decoder's FlagW strobe
  localparam int FLAGW_CV = 1;
  localparam int FLAGW_NZ = 0;

endpackage

// File: rtl/cond_check.sv
// Pure combinational condition evaluator: (Cond, Flags) -> CondEx.
// Kept stateless so a pipelined variant can drop it into any stage.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n_flag;
  logic z_flag;
  logic c_flag;
  logic v_flag;

  assign n_flag = Flags[FLAG_N];
  assign z_flag = Flags[FLAG_Z];
  assign c_flag = Flags[FLAG_C];
  assign v_flag = Flags[FLAG_V];

  // Decode the condition field against the supplied flags
  always_comb begin
    CondEx = 1'b0;
    case (cond_e'(Cond))
      EQ: CondEx = z_flag;
      NE: CondEx = ~z_flag;
      CS: CondEx = c_flag;
      CC: CondEx = ~c_flag;
      MI: CondEx = n_flag;
      PL: CondEx = ~n_flag;
      VS: CondEx = v_flag;
      VC: CondEx = ~v_flag;
      HI: CondEx = c_flag & ~z_flag;
      LS: CondEx = ~c_flag | z_flag;
      GE: CondEx = (n_flag == v_flag);
      LT: CondEx = (n_flag != v_flag);
      GT: CondEx = ~z_flag & (n_flag == v_flag);
      LE: CondEx = z_flag | (n_flag != v_flag);
      AL: CondEx = 1'b1;
      NV: CondEx = 1'b0;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage: holds the NZCV flags, evaluates the
// instruction condition, gates the decoder write strobes and updates the
// flags from the ALU. Optional execution/squash counters are built only
// when COND_PERF_CNT_EN is defined.
module cond_logic
  import cond_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic [3:0]       Flags
`ifdef COND_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] ExecCount,
  output logic [CNT_W-1:0] SquashCount
`endif
);

  logic [3:0] flags_reg;
  logic [3:0] flags_next;
  logic       cond_ex;
  logic       wr_nz;
  logic       wr_cv;

  // Condition is judged against the registered flags, never ALUFlags
  cond_check u_cond_check (
    .Cond   (Cond),
    .Flags  (flags_reg),
    .CondEx (cond_ex)
  );

  assign CondEx   = cond_ex;
  assign PCSrc    = PCS  & cond_ex;
  assign RegWrite = RegW & cond_ex;
  assign MemWrite = MemW & cond_ex;
  assign Flags    = flags_reg;

  // A squashed instruction never touches the flags
  assign wr_nz = en & cond_ex & FlagW[FLAGW_NZ];
  assign wr_cv = en & cond_ex & FlagW[FLAGW_CV];

  // Next flag value: N,Z and C,V halves written independently
  always_comb begin
    flags_next = flags_reg;
    if (wr_nz) begin
      flags_next[FLAG_N] = ALUFlags[FLAG_N];
      flags_next[FLAG_Z] = ALUFlags[FLAG_Z];
    end
    if (wr_cv) begin
      flags_next[FLAG_C] = ALUFlags[FLAG_C];
      flags_next[FLAG_V] = ALUFlags[FLAG_V];
    end
  end

  // Flag register; reset overrides any write in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_reg <= 4'b0000;
    end else begin
      flags_reg <= flags_next;
    end
  end

`ifdef COND_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] exec_cnt_reg;
  logic [CNT_W-1:0] exec_cnt_next;
  logic [CNT_W-1:0] squash_cnt_reg;
  logic [CNT_W-1:0] squash_cnt_next;

  // Saturating counters: executed vs squashed, only on valid cycles
  always_comb begin
    exec_cnt_next   = exec_cnt_reg;
    squash_cnt_next = squash_cnt_reg;
    if (en) begin
      if (cond_ex) begin
        if (exec_cnt_reg != CNT_MAX) exec_cnt_next = exec_cnt_reg + CNT_ONE;
      end else begin
        if (squash_cnt_reg != CNT_MAX) squash_cnt_next = squash_cnt_reg + CNT_ONE;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      exec_cnt_reg   <= '0;
      squash_cnt_reg <= '0;
    end else begin
      exec_cnt_reg   <= exec_cnt_next;
      squash_cnt_reg <= squash_cnt_next;
    end
  end

  assign ExecCount   = exec_cnt_reg;
  assign SquashCount = squash_cnt_reg;
`else
  // Counters not built in this configuration
`endif

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: a table of directed vectors with
// hand-computed results, a full Cond x Flags sweep, reset priority and,
// when COND_PERF_CNT_EN is defined, counter and saturation sequences.
module tb_cond_logic;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       CondEx;
  logic [3:0] Flags;

`ifdef COND_PERF_CNT_EN
  logic [31:0] ExecCount;
  logic [31:0] SquashCount;
  logic        s_PCSrc, s_RegWrite, s_MemWrite, s_CondEx;
  logic [3:0]  s_Flags;
  logic [3:0]  s_ExecCount;
  logic [3:0]  s_SquashCount;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cond_logic #(.CNT_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .Cond        (Cond),
    .ALUFlags    (ALUFlags),
    .FlagW       (FlagW),
    .PCS         (PCS),
    .RegW        (RegW),
    .MemW        (MemW),
    .PCSrc       (PCSrc),
    .RegWrite    (RegWrite),
    .MemWrite    (MemWrite),
    .CondEx      (CondEx),
    .Flags       (Flags)
`ifdef COND_PERF_CNT_EN
    ,
    .ExecCount   (ExecCount),
    .SquashCount (SquashCount)
`endif
  );

`ifdef COND_PERF_CNT_EN
  cond_logic #(.CNT_W(4)) dut_sat (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .Cond        (Cond),
    .ALUFlags    (ALUFlags),
    .FlagW       (FlagW),
    .PCS         (PCS),
    .RegW        (RegW),
    .MemW        (MemW),
    .PCSrc       (s_PCSrc),
    .RegWrite    (s_RegWrite),
    .MemWrite    (s_MemWrite),
    .CondEx      (s_CondEx),
    .Flags       (s_Flags),
    .ExecCount   (s_ExecCount),
    .SquashCount (s_SquashCount)
  );
`endif

  typedef struct {
    logic       en;
    logic [3:0] cond;
    logic [3:0] alu;
    logic [1:0] fw;
    logic       pcs;
    logic       regw;
    logic       memw;
    logic       exp_cx;
    logic       exp_pcsrc;
    logic       exp_regwrite;
    logic       exp_memwrite;
    logic [3:0] exp_flags;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(logic e, logic [3:0] c, logic [3:0] a, logic [1:0] w,
                              logic p, logic r, logic m, logic cx, logic po,
                              logic ro, logic mo, logic [3:0] fl);
    vec_t v;
    v.en = e; v.cond = c; v.alu = a; v.fw = w;
    v.pcs = p; v.regw = r; v.memw = m;
    v.exp_cx = cx; v.exp_pcsrc = po; v.exp_regwrite = ro; v.exp_memwrite = mo;
    v.exp_flags = fl;
    return v;
  endfunction

  // Reference condition: even codes give a base test, odd codes invert it
  function automatic logic ref_cond(logic [3:0] c, logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & !z;
      3'd5: base = (n == v);
      3'd6: base = !z & (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; Cond = 4'b0; ALUFlags = 4'b0; FlagW = 2'b0;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;

    //                en  cond     alu      fw     p     r     m     cx    po    ro    mo    flags
    vecs[0]  = mk(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    vecs[1]  = mk(1'b1, 4'b1110, 4'b0100, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0100);
    vecs[2]  = mk(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0100);
    vecs[3]  = mk(1'b1, 4'b1110, 4'b1011, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0111);
    vecs[4]  = mk(1'b0, 4'b1110, 4'b0000, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0111);
    vecs[5]  = mk(1'b1, 4'b0001, 4'b1000, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0111);
    vecs[6]  = mk(1'b1, 4'b1110, 4'b1000, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1000);
    vecs[7]  = mk(1'b1, 4'b0000, 4'b0110, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000);
    vecs[8]  = mk(1'b1, 4'b0100, 4'b0001, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1001);
    vecs[9]  = mk(1'b1, 4'b1010, 4'b0100, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0101);
    vecs[10] = mk(1'b1, 4'b1100, 4'b0000, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0101);
    vecs[11] = mk(1'b1, 4'b1111, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0101);
    vecs[12] = mk(1'b1, 4'b1101, 4'b0010, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0010);
    vecs[13] = mk(1'b1, 4'b1000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0010);

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_flags", {28'd0, Flags}, 32'h0);
`ifdef COND_PERF_CNT_EN
    check("reset_exec", ExecCount, 32'd0);
    check("reset_squash", SquashCount, 32'd0);
`endif

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      en = vecs[i].en; Cond = vecs[i].cond; ALUFlags = vecs[i].alu; FlagW = vecs[i].fw;
      PCS = vecs[i].pcs; RegW = vecs[i].regw; MemW = vecs[i].memw;
      #1;
      check($sformatf("v%0d_condex", i), {31'd0, CondEx}, {31'd0, vecs[i].exp_cx});
      check($sformatf("v%0d_pcsrc", i), {31'd0, PCSrc}, {31'd0, vecs[i].exp_pcsrc});
      check($sformatf("v%0d_regwrite", i), {31'd0, RegWrite}, {31'd0, vecs[i].exp_regwrite});
      check($sformatf("v%0d_memwrite", i), {31'd0, MemWrite}, {31'd0, vecs[i].exp_memwrite});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_flags", i), {28'd0, Flags}, {28'd0, vecs[i].exp_flags});
    end

    // Reset beats a simultaneous enabled flag write
    @(negedge clk);
    reset = 1'b1; en = 1'b1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1111;
    @(posedge clk);
    #1;
    check("reset_wins_flags", {28'd0, Flags}, 32'h0);
    @(negedge clk);
    reset = 1'b0; en = 1'b0; FlagW = 2'b00;

    // Sweep every flag value against every condition code
    for (int f = 0; f < 16; f++) begin
      @(negedge clk);
      en = 1'b1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'(f);
      PCS = 1'b1; RegW = 1'b0; MemW = 1'b1;
      @(posedge clk);
      #1;
      en = 1'b0; FlagW = 2'b00;
      check($sformatf("sweep_load_f%0h", f), {28'd0, Flags}, {28'd0, 4'(f)});
      for (int c = 0; c < 16; c++) begin
        Cond = 4'(c);
        #1;
        check($sformatf("sweep_c%0h_f%0h", c, f), {31'd0, CondEx},
              {31'd0, ref_cond(4'(c), 4'(f))});
      end
      check($sformatf("sweep_gate_f%0h", f), {31'd0, MemWrite}, {31'd0, ref_cond(4'hF, 4'(f))});
    end

`ifdef COND_PERF_CNT_EN
    // 5 passing, one idle, 3 squashed
    @(negedge clk);
    reset = 1'b1; en = 1'b0; FlagW = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 9; k++) begin
      en   = (k != 5);
      Cond = (k < 5) ? 4'b1110 : 4'b1111;
      @(negedge clk);
    end
    en = 1'b0;
    check("cnt_exec_5", ExecCount, 32'd5);
    check("cnt_squash_3", SquashCount, 32'd3);
    check("sat_exec_5", {28'd0, s_ExecCount}, 32'd5);

    // 20 passing cycles saturate the 4-bit counter
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; en = 1'b1; Cond = 4'b1110;
    repeat (20) @(negedge clk);
    en = 1'b0;
    check("cnt_exec_20", ExecCount, 32'd20);
    check("sat_exec_15", {28'd0, s_ExecCount}, 32'd15);
    check("sat_squash_0", {28'd0, s_SquashCount}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
